// File: rtl/modulation_oscillator.sv
// Square-wave modulation oscillator for the lock-in path.
// Produces the phase counter and sign for the demodulating mixer, plus a
// signed +/-amplitude plant drive. Software loads a period/amplitude set
// into a pending slot; the set takes effect only on a full-period boundary.
module modulation_oscillator #(
  parameter int counterBitDepth   = 5,
  parameter int ampBitDepth       = 12,
  parameter int HALF_PERIOD_RESET = 16
) (
  input  logic                              clk64,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              loadIn,
  input  logic [counterBitDepth-1:0]        halfPeriodIn,
  input  logic signed [ampBitDepth-1:0]     amplitudeIn,
  output logic                              loadAck,
  output logic                              pendingOut,
  output logic [counterBitDepth-1:0]        counterOut,
  output logic                              signOut,
  output logic                              syncOut,
  output logic signed [ampBitDepth:0]       modOut
);

  localparam int CW = counterBitDepth;
  localparam int AW = ampBitDepth;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HALF_RST = CW'(HALF_PERIOD_RESET);
  localparam logic [AW-1:0] AMP_ZERO = {AW{1'b0}};
  localparam logic [AW:0]   MOD_ZERO = {(AW+1){1'b0}};

  // Run state is simply the sampled enable; no extra state register needed.
  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  run_state_t state_s;

  // Internal state registers (counter/sign are the counterOut/signOut ports).
  logic [CW-1:0]        active_half_r;
  logic signed [AW-1:0] active_amp_r;
  logic [CW-1:0]        pend_half_r;
  logic signed [AW-1:0] pend_amp_r;
  logic                 pend_valid_r;

  // Next-state values.
  logic [CW-1:0]        counter_s;
  logic                 sign_s;
  logic [CW-1:0]        active_half_s;
  logic signed [AW-1:0] active_amp_s;
  logic [CW-1:0]        pend_half_s;
  logic signed [AW-1:0] pend_amp_s;
  logic                 pend_valid_s;
  logic                 sync_s;
  logic                 ack_s;
  logic signed [AW:0]   amp_ext_s;
  logic signed [AW:0]   mod_s;
  logic                 at_end_s;

  assign state_s  = enable ? RUNNING : STOPPED;
  assign at_end_s = (counterOut == (active_half_r - CNT_ONE));

  // Next-state: phase advance, boundary handover of the pending set, capture.
  always_comb begin
    counter_s     = counterOut;
    sign_s        = signOut;
    active_half_s = active_half_r;
    active_amp_s  = active_amp_r;
    pend_half_s   = pend_half_r;
    pend_amp_s    = pend_amp_r;
    pend_valid_s  = pend_valid_r;
    sync_s        = 1'b0;
    ack_s         = 1'b0;

    case (state_s)
      RUNNING: begin
        if (at_end_s) begin
          counter_s = CNT_ZERO;
          sign_s    = ~signOut;
          // Negative-to-positive wrap starts a new full period.
          if (!signOut) begin
            sync_s = 1'b1;
            if (pend_valid_r) begin
              active_half_s = pend_half_r;
              active_amp_s  = pend_amp_r;
              pend_valid_s  = 1'b0;
              ack_s         = 1'b1;
            end else begin
              ack_s = 1'b0;
            end
          end else begin
            sync_s = 1'b0;
          end
        end else begin
          counter_s = counterOut + CNT_ONE;
        end
      end
      STOPPED: begin
        counter_s = counterOut;
      end
      default: begin
        counter_s = counterOut;
      end
    endcase

    // Capture after the boundary handover so a same-cycle load stays pending.
    if (loadIn) begin
      pend_half_s  = (halfPeriodIn == CNT_ZERO) ? CNT_ONE : halfPeriodIn;
      pend_amp_s   = amplitudeIn;
      pend_valid_s = 1'b1;
    end else begin
      pend_valid_s = pend_valid_s;
    end

    // Full-width negation keeps -(-2^(AW-1)) representable.
    amp_ext_s = {active_amp_s[AW-1], active_amp_s};
    if (sign_s) begin
      mod_s = amp_ext_s;
    end else begin
      mod_s = -amp_ext_s;
    end
  end

  // State and output registers; all outputs change on the same edge.
  always_ff @(posedge clk64) begin
    if (reset) begin
      counterOut    <= CNT_ZERO;
      signOut       <= 1'b1;
      syncOut       <= 1'b0;
      loadAck       <= 1'b0;
      modOut        <= MOD_ZERO;
      active_half_r <= HALF_RST;
      active_amp_r  <= AMP_ZERO;
      pend_half_r   <= CNT_ONE;
      pend_amp_r    <= AMP_ZERO;
      pend_valid_r  <= 1'b0;
    end else begin
      counterOut    <= counter_s;
      signOut       <= sign_s;
      syncOut       <= sync_s;
      loadAck       <= ack_s;
      modOut        <= mod_s;
      active_half_r <= active_half_s;
      active_amp_r  <= active_amp_s;
      pend_half_r   <= pend_half_s;
      pend_amp_r    <= pend_amp_s;
      pend_valid_r  <= pend_valid_s;
    end
  end

  assign pendingOut = pend_valid_r;

endmodule

// File: tb/tb_modulation_oscillator.sv
// Directed bench for modulation_oscillator with a cycle-level scoreboard.
module tb_modulation_oscillator;

  logic               clk64 = 1'b0;
  logic               reset;
  logic               enable;
  logic               loadIn;
  logic [4:0]         halfPeriodIn;
  logic signed [11:0] amplitudeIn;
  logic               loadAck;
  logic               pendingOut;
  logic [4:0]         counterOut;
  logic               signOut;
  logic               syncOut;
  logic signed [12:0] modOut;

  modulation_oscillator #(
    .counterBitDepth(5),
    .ampBitDepth(12),
    .HALF_PERIOD_RESET(16)
  ) dut (
    .clk64(clk64), .reset(reset), .enable(enable), .loadIn(loadIn),
    .halfPeriodIn(halfPeriodIn), .amplitudeIn(amplitudeIn),
    .loadAck(loadAck), .pendingOut(pendingOut), .counterOut(counterOut),
    .signOut(signOut), .syncOut(syncOut), .modOut(modOut)
  );

  always #5 clk64 = ~clk64;

  typedef struct {
    int cnt; int sign; int sync; int ack; int pend; int mod;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  // Behavioural reference state.
  int m_cnt, m_sign, m_half, m_amp, m_ph, m_pa, m_pv;

  // Observations derived from the DUT for directed timing checks.
  int since_sync = 0;
  int last_period = 0;
  int ack_count = 0;
  int obs_ack = 0;
  int obs_pend = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle, push the predicted outputs, then compare after the edge.
  task automatic step(input logic rst, input logic en, input logic ld,
                      input int hp, input int amp);
    exp_t e;
    exp_t got;
    reset = rst; enable = en; loadIn = ld;
    halfPeriodIn = 5'(hp); amplitudeIn = 12'(amp);
    e.sync = 0; e.ack = 0;
    if (rst) begin
      m_cnt = 0; m_sign = 1; m_half = 16; m_amp = 0; m_pv = 0;
    end else begin
      if (en) begin
        if (m_cnt == m_half - 1) begin
          m_cnt = 0;
          if (m_sign == 0) begin
            m_sign = 1; e.sync = 1;
            if (m_pv == 1) begin
              m_half = m_ph; m_amp = m_pa; m_pv = 0; e.ack = 1;
            end
          end else begin
            m_sign = 0;
          end
        end else begin
          m_cnt++;
        end
      end
      if (ld) begin
        m_ph = (hp == 0) ? 1 : hp; m_pa = amp; m_pv = 1;
      end
    end
    e.cnt = m_cnt; e.sign = m_sign; e.pend = m_pv;
    e.mod = (m_sign == 1) ? m_amp : -m_amp;
    exp_q.push_back(e);
    @(posedge clk64);
    #1;
    got = exp_q.pop_front();
    chk("counterOut", int'(counterOut), got.cnt);
    chk("signOut", int'(signOut), got.sign);
    chk("syncOut", int'(syncOut), got.sync);
    chk("loadAck", int'(loadAck), got.ack);
    chk("pendingOut", int'(pendingOut), got.pend);
    chk("modOut", int'(modOut), got.mod);
    since_sync++;
    if (syncOut === 1'b1) begin
      last_period = since_sync;
      since_sync = 0;
    end
    if (loadAck === 1'b1) ack_count++;
    obs_ack = int'(loadAck);
    obs_pend = int'(pendingOut);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; loadIn = 1'b0;
    halfPeriodIn = 5'd0; amplitudeIn = 12'sd0;

    // Reset and default 16-cycle half period, zero drive.
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    since_sync = 0;
    run(70);
    chk("default_period", last_period, 32);

    // Mid-period load of (4, 100).
    run(5);
    step(1'b0, 1'b1, 1'b1, 4, 100);
    chk("pending_after_load", obs_pend, 1);
    run(40);
    chk("period_4", last_period, 8);

    // Two loads before a boundary: last wins, single ack.
    ack_count = 0;
    step(1'b0, 1'b1, 1'b1, 3, 50);
    step(1'b0, 1'b1, 1'b1, 6, -7);
    run(40);
    chk("single_ack", ack_count, 1);
    chk("period_6", last_period, 12);

    // Zero half-period clamped to 1, most negative amplitude.
    step(1'b0, 1'b1, 1'b1, 0, -2048);
    run(20);
    chk("period_clamped", last_period, 2);

    // Pause mid half-period with a load during the pause.
    step(1'b0, 1'b1, 1'b1, 5, 300);
    run(22);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, (i == 2) ? 1'b1 : 1'b0, 7, -1);
    chk("pending_in_pause", obs_pend, 1);
    run(40);
    chk("period_7", last_period, 14);

    // Load landing on the same cycle as a boundary that consumes an older set.
    step(1'b0, 1'b1, 1'b1, 2, 11);
    begin
      int guard = 0;
      while (!(m_cnt == m_half - 1 && m_sign == 0) && guard < 100) begin
        run(1);
        guard++;
      end
      chk("boundary_reached", (guard < 100) ? 1 : 0, 1);
    end
    step(1'b0, 1'b1, 1'b1, 4, 22);
    chk("same_cycle_ack", obs_ack, 1);
    chk("same_cycle_pending", obs_pend, 1);
    run(20);

    // Reset with a pending set: discarded, default period resumes.
    step(1'b0, 1'b1, 1'b1, 9, 9);
    run(2);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    ack_count = 0;
    since_sync = 0;
    run(70);
    chk("no_ack_after_reset", ack_count, 0);
    chk("period_after_reset", last_period, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modulation_oscillator.md
# modulation_oscillator

Square-wave modulation oscillator that drives the lock-in path: generates the phase counter and sign consumed by the demodulating mixer, plus a signed ±amplitude drive for the plant. Period and amplitude are software-loaded through a pulse/ack handshake and take effect only on a full-period boundary, so neither the plant drive nor the mixer reference ever sees a truncated half cycle. Sits beside the mixer bank in the usrp_std toplevel, clocked by clk64.

## Interface
- counterBitDepth, 5, width of the half-period counter and of the period setting
- ampBitDepth, 12, width of the signed amplitude input
- HALF_PERIOD_RESET, 16, active half-period after reset (must be ≥1 and < 2^counterBitDepth)

- clk64  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- enable  in  1  run when high; freeze counter/sign when low
- loadIn  in  1  one-cycle strobe; captures halfPeriodIn and amplitudeIn into the pending set
- halfPeriodIn  in  counterBitDepth  requested half-period in clk64 cycles
- amplitudeIn  in  signed ampBitDepth  requested drive amplitude
- loadAck  out  1  one-cycle pulse on the cycle the pending set becomes active
- pendingOut  out  1  high while a captured set awaits a period boundary
- counterOut  out  counterBitDepth  phase counter, 0..activeHalf-1 (mixer counterIn)
- signOut  out  1  oscillator sign, 1 = positive half (mixer signIn)
- syncOut  out  1  one-cycle pulse on the first cycle of each full period
- modOut  out  signed ampBitDepth+1  sign ? +activeAmp : -activeAmp

## Operation
- Registers: counter, sign, activeHalf, activeAmp, pendingHalf, pendingAmp, pendingValid; all outputs registered.
- States: STOPPED (enable low) and RUNNING (enable high); state is enable sampled, no separate FSM register beyond it.
- RUNNING, counter < activeHalf-1: counter increments.
- RUNNING, counter == activeHalf-1: counter -> 0, sign toggles (wrap).
- Wrap with sign 0->1 is a period boundary: syncOut pulses; if pendingValid, activeHalf/activeAmp <- pending values, pendingValid -> 0, loadAck pulses. New half-period governs the period that starts there.
- halfPeriodIn == 0 is clamped to 1 at capture (counter stays 0, sign toggles every cycle).
- loadIn while pendingValid: pending set overwritten (last wins); only one loadAck for the surviving set.
- loadIn on the same cycle as a boundary that consumes an older pending set: old set is applied and acked; new set is captured and remains pending.
- STOPPED: counter, sign, modOut, pending state hold; loadIn still captures; no syncOut/loadAck.
- modOut = sign ? activeAmp : -activeAmp, sign-extended to ampBitDepth+1 bits; -(-2^(ampBitDepth-1)) is representable, no saturation.

## Timing
- Reset values: counterOut 0, signOut 1, syncOut 0, loadAck 0, pendingOut 0, modOut 0; activeHalf = HALF_PERIOD_RESET, activeAmp 0, pending cleared.
- Reset mid-operation discards any pending set without loadAck.
- counterOut, signOut, modOut, syncOut, loadAck change on the same clk64 edge (zero relative skew).
- loadIn at edge N -> pendingOut high from N+1.
- Full period = 2*activeHalf cycles; signOut high for the first activeHalf cycles of each period.
- Boundary at edge B: counterOut 0, signOut 1, syncOut 1, loadAck 1 (if pending), modOut = +newAmp, pendingOut 0, all visible after B.
- enable low at edge E: outputs after E equal those after E-1; resume continues the count where it stopped.

## Test plan
- Reset, enable high, no load -> counterOut 0..15 repeating, signOut toggles every 16 cycles, syncOut every 32 cycles, modOut 0 throughout.
- loadIn with halfPeriod 4, amplitude 100 mid-period -> pendingOut until next sign 0->1 wrap; then loadAck+syncOut same cycle, modOut +100 for 4 cycles, -100 for 4, period 8.
- Two loads (3,50) then (6,-7) before a boundary -> single loadAck, period 12, modOut -7 then +7.
- Load halfPeriod 0, amplitude -2048 -> after boundary signOut toggles every cycle, counterOut stuck 0, modOut alternates -2048/+2048.
- enable low for 5 cycles mid half-period -> all outputs frozen, count resumes exactly; load during pause applied at next boundary after resume.
- Reset asserted with pending set -> outputs return to reset values, no loadAck, old HALF_PERIOD_RESET period resumes.
